// File: rtl/game_screen_ctl.sv
// PONG screen sequencer: MENU/PLAY/PAUSE/OVER with frame-aligned commits and VGA stream select.
// Build option: define SCREEN_PAUSE_EN to enable the right-click PAUSE screen and its dimmed pixel path.
module game_screen_ctl #(
  parameter int START_X0    = 412,
  parameter int START_X1    = 612,
  parameter int START_Y0    = 360,
  parameter int START_Y1    = 408,
  parameter int OVER_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic        game_over,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic [11:0] rgb_menu,
  input  logic [11:0] rgb_game,
  output logic [1:0]  screen,
  output logic        game_en,
  output logic        game_rst,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic [11:0] rgb_out
);

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } screen_t;

  typedef struct packed {
    logic    vld;
    screen_t nxt;
  } pend_t;

  localparam logic [11:0] X0 = 12'(START_X0);
  localparam logic [11:0] X1 = 12'(START_X1);
  localparam logic [11:0] Y0 = 12'(START_Y0);
  localparam logic [11:0] Y1 = 12'(START_Y1);
  localparam logic [7:0]  OVER_LAST = 8'(OVER_FRAMES - 1);

  screen_t     scr_q, scr_d;
  pend_t       pend_q, pend_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        left_d, vsync_d;
  logic        left_clk, right_clk, frame, hit, commit, game_rst_d;
  logic [11:0] rgb_sel;

  assign left_clk = mouse_left & ~left_d;
  assign frame    = vsync_in & ~vsync_d;
  assign hit      = (xpos >= X0) && (xpos <= X1) && (ypos >= Y0) && (ypos <= Y1);
  assign commit   = frame & pend_q.vld;

`ifdef SCREEN_PAUSE_EN
  logic right_d;
  assign right_clk = mouse_right & ~right_d;
`else
  logic right_unused;
  assign right_unused = mouse_right;
  assign right_clk    = 1'b0;
`endif

  // The edge-detect register for vsync doubles as the one-cycle sync delay.
  assign vsync_out = vsync_d;
  assign screen    = scr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q     <= S_MENU;
      pend_q    <= '0;
      cnt_q     <= '0;
      left_d    <= 1'b0;
      vsync_d   <= 1'b0;
      hsync_out <= 1'b0;
      rgb_out   <= '0;
      game_en   <= 1'b0;
      game_rst  <= 1'b1;
`ifdef SCREEN_PAUSE_EN
      right_d   <= 1'b0;
`endif
    end else begin
      scr_q     <= scr_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      left_d    <= mouse_left;
      vsync_d   <= vsync_in;
      hsync_out <= hsync_in;
      rgb_out   <= rgb_sel;
      game_en   <= (scr_d == S_PLAY);
      game_rst  <= game_rst_d;
`ifdef SCREEN_PAUSE_EN
      right_d   <= mouse_right;
`endif
    end
  end

  // Requests are judged against the screen being entered this cycle, so a
  // click coinciding with a commit is latched for the following frame edge.
  always_comb begin
    scr_d      = scr_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    game_rst_d = 1'b0;
    if (commit) begin
      scr_d      = pend_q.nxt;
      pend_d.vld = 1'b0;
      cnt_d      = '0;
      game_rst_d = (scr_q == S_MENU) && (pend_q.nxt == S_PLAY);
    end else if (frame && (scr_q == S_OVER)) begin
      if (cnt_q == OVER_LAST) begin
        scr_d = S_MENU;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    case (scr_d)
      S_MENU: begin
        if (left_clk && hit) pend_d = '{vld: 1'b1, nxt: S_PLAY};
      end
      S_PLAY: begin
        if (game_over)
          pend_d = '{vld: 1'b1, nxt: S_OVER};
        else if (right_clk && !(pend_d.vld && (pend_d.nxt == S_OVER)))
          pend_d = pend_d.vld ? '{vld: 1'b0, nxt: S_PLAY} : '{vld: 1'b1, nxt: S_PAUSE};
      end
      S_PAUSE: begin
        if (right_clk)
          pend_d = pend_d.vld ? '{vld: 1'b0, nxt: S_PAUSE} : '{vld: 1'b1, nxt: S_PLAY};
      end
      default: ;
    endcase
  end

  always_comb begin
    rgb_sel = rgb_menu;
    case (scr_q)
      S_PLAY:  rgb_sel = rgb_game;
`ifdef SCREEN_PAUSE_EN
      S_PAUSE: rgb_sel = {1'b0, rgb_game[11:9], 1'b0, rgb_game[7:5], 1'b0, rgb_game[3:1]};
`endif
      default: rgb_sel = rgb_menu;
    endcase
  end

endmodule

// File: tb/tb_game_screen_ctl.sv
// Bench for game_screen_ctl: directed steps then random mouse/game_over traffic vs a frame-level model.
module tb_game_screen_ctl;
  localparam int OVF = 4;
  localparam int FL  = 32;
`ifdef SCREEN_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mouse_left, mouse_right, game_over;
  logic        vsync_in, hsync_in;
  logic [11:0] rgb_menu, rgb_game;
  logic [1:0]  screen;
  logic        game_en, game_rst, vsync_out, hsync_out;
  logic [11:0] rgb_out;

  game_screen_ctl #(.OVER_FRAMES(OVF)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .mouse_right(mouse_right), .game_over(game_over),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .rgb_menu(rgb_menu), .rgb_game(rgb_game),
    .screen(screen), .game_en(game_en), .game_rst(game_rst),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  int grst_seen = 0;
  bit fix_rgb = 1'b0;

  // Frame-level model: per-frame event tallies resolved at each vsync rise.
  int          m_scr, over_edges, right_cnt;
  bit          menu_hit, over_req, pl, pr, pv;
  logic [11:0] e_rgb;
  bit          e_hs, e_vs, e_grst;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] want);
    checks = checks + 1;
    assert (obs === want) passes = passes + 1;
    else $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, want, cyc);
  endtask

  task automatic model_edge();
    bit lc, rc, fr, inbox;
    if (rst) begin
      m_scr = 0; over_edges = 0; right_cnt = 0;
      menu_hit = 0; over_req = 0; pl = 0; pr = 0; pv = 0;
      e_rgb = '0; e_hs = 0; e_vs = 0; e_grst = 1;
      return;
    end
    lc = mouse_left && !pl;
    rc = mouse_right && !pr;
    fr = vsync_in && !pv;
    pl = mouse_left; pr = mouse_right; pv = vsync_in;
    e_hs = hsync_in; e_vs = vsync_in; e_grst = 0;
    case (m_scr)
      1:       e_rgb = rgb_game;
      2:       e_rgb = (rgb_game >> 1) & 12'h777;
      default: e_rgb = rgb_menu;
    endcase
    if (fr) begin
      if (m_scr == 3) begin
        over_edges++;
        if (over_edges == OVF) m_scr = 0;
      end else if (m_scr == 0 && menu_hit) begin
        m_scr = 1; e_grst = 1;
      end else if (m_scr == 1 && over_req) begin
        m_scr = 3; over_edges = 0;
      end else if (PAUSE_ON && m_scr == 1 && right_cnt % 2 == 1) begin
        m_scr = 2;
      end else if (PAUSE_ON && m_scr == 2 && right_cnt % 2 == 1) begin
        m_scr = 1;
      end
      menu_hit = 0; over_req = 0; right_cnt = 0;
    end
    inbox = xpos >= 12'd412 && xpos <= 12'd612 && ypos >= 12'd360 && ypos <= 12'd408;
    if (m_scr == 0 && lc && inbox) menu_hit = 1;
    if (m_scr == 1 && game_over) over_req = 1;
    if ((m_scr == 1 || m_scr == 2) && rc) right_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("screen", {10'b0, screen}, 12'(m_scr));
    check("game_en", {11'b0, game_en}, {11'b0, m_scr == 1});
    check("game_rst", {11'b0, game_rst}, {11'b0, e_grst});
    check("rgb_out", rgb_out, e_rgb);
    check("hsync_out", {11'b0, hsync_out}, {11'b0, e_hs});
    check("vsync_out", {11'b0, vsync_out}, {11'b0, e_vs});
    grst_seen += int'(game_rst);
    cyc++;
    vsync_in = (cyc % FL) < 3;
    hsync_in = (cyc % 8) == 0;
    if (!fix_rgb) begin
      rgb_menu = 12'($urandom);
      rgb_game = 12'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < FL && (cyc % FL) != ph; i++) tick();
  endtask

  task automatic click_left(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    mouse_left = 1; tick(); tick();
    mouse_left = 0; tick();
  endtask

  task automatic click_right();
    mouse_right = 1; tick(); tick();
    mouse_right = 0; tick();
  endtask

  initial begin
    rst = 1; xpos = 0; ypos = 0; mouse_left = 0; mouse_right = 0; game_over = 0;
    vsync_in = 1; hsync_in = 1; rgb_menu = 12'h123; rgb_game = 12'h456;
    repeat (3) tick();
    check("rst_screen", {10'b0, screen}, 12'd0);
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_grst_held", {11'b0, game_rst}, 12'd1);
    rst = 0;
    tick();
    check("grst_release", {11'b0, game_rst}, 12'd0);
    run(3 * FL);
    check("idle_menu", {10'b0, screen}, 12'd0);

    // Clicks one pixel outside the start button
    align(10);
    click_left(411, 380);
    click_left(500, 409);
    run(2 * FL);
    check("miss_menu", {10'b0, screen}, 12'd0);

    // Start click mid-frame: commit waits for the vsync edge
    align(16);
    grst_seen = 0;
    click_left(500, 380);
    check("wait_edge", {10'b0, screen}, 12'd0);
    run(FL);
    check("menu_to_play", {10'b0, screen}, 12'd1);
    check("grst_single", 12'(grst_seen), 12'd1);
    check("en_play", {11'b0, game_en}, 12'd1);

    // game_over beats a same-cycle pause request
    align(16);
    game_over = 1; mouse_right = 1; tick();
    mouse_right = 0; tick();
    game_over = 0;
    run(FL);
    check("play_to_over", {10'b0, screen}, 12'd3);
    check("en_over", {11'b0, game_en}, 12'd0);
    run(3 * FL);
    check("over_hold", {10'b0, screen}, 12'd3);
    run(FL);
    check("over_to_menu", {10'b0, screen}, 12'd0);

    align(16);
    click_left(600, 400);
    run(FL);
    check("replay", {10'b0, screen}, 12'd1);

    // Pause and dim path
    fix_rgb = 1; rgb_game = 12'hFA6; rgb_menu = 12'h0F0;
    align(16);
    click_right();
    run(FL);
    check("pause", {10'b0, screen}, PAUSE_ON ? 12'd2 : 12'd1);
    check("pause_rgb", rgb_out, PAUSE_ON ? 12'h753 : 12'hFA6);
    align(16);
    click_right();
    run(FL);
    check("unpause", {10'b0, screen}, 12'd1);
    check("unpause_rgb", rgb_out, 12'hFA6);
    fix_rgb = 0;

    // Two right clicks inside one frame cancel out
    align(4);
    click_right();
    click_right();
    run(FL);
    check("toggle_cancel", {10'b0, screen}, 12'd1);

    // Reset mid-frame drops a pending OVER
    align(10);
    game_over = 1; tick(); tick();
    game_over = 0;
    rst = 1; tick();
    check("rst_mid_screen", {10'b0, screen}, 12'd0);
    check("rst_mid_grst", {11'b0, game_rst}, 12'd1);
    rst = 0;
    run(2 * FL);
    check("rst_no_commit", {10'b0, screen}, 12'd0);

    // Random traffic around the start button
    for (int i = 0; i < 70 * FL; i++) begin
      if ($urandom_range(0, 9) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 11) == 0) mouse_right = ~mouse_right;
      xpos = 12'($urandom_range(400, 620));
      ypos = 12'($urandom_range(350, 420));
      game_over = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
